// File: rtl/blockade_vram_if.sv
// Signal bundle linking the Blockade VRAM arbiter, its two clients and the 1024x8 single-port RAM.
interface blockade_vram_if;
    logic       ce_vid;
    logic [9:0] vid_addr;
    logic [7:0] vid_data;
    logic       vblank;
    logic       cpu_req;
    logic       cpu_we;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_ack;
    logic       cpu_ready;
    logic       clear_busy;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_q;

    // Environment side: video timing, CPU decode and the RAM macro.
    modport master (
        output ce_vid, vid_addr, vblank, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
        input  vid_data, cpu_rdata, cpu_ack, cpu_ready, clear_busy, ram_addr, ram_we, ram_wdata
    );

    // Arbiter side.
    modport slave (
        input  ce_vid, vid_addr, vblank, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
        output vid_data, cpu_rdata, cpu_ack, cpu_ready, clear_busy, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/blockade_vram_arbiter.sv
// Shares one 1024x8 synchronous VRAM between video fetch and the 8080, clearing it after reset.
// Optional VRAM_VBLANK_ONLY_EN restricts CPU writes to vertical blank.
module blockade_vram_arbiter (
    input  logic           clk,
    input  logic           reset,
    blockade_vram_if.slave bus
);
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam logic [AW-1:0] LAST_ADDR = AW'(1023);

    typedef enum logic {CLEAR, RUN} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] clr_cnt;
    req_t          pend;
    logic          pend_valid;
    logic          pend_issued;
    logic          pend_valid_next;
    logic [1:0]    tag;
    logic [AW-1:0] addr_hold;

    logic          wr_slot_ok;
    logic          vid_serve;
    logic          cpu_issue;
    logic          cpu_wr_issue;
    logic          cpu_rd_issue;
    logic          req_take;
    logic          pend_done;
    logic [AW-1:0] mux_addr;
    logic          mux_we;
    logic [DW-1:0] mux_wdata;

`ifdef VRAM_VBLANK_ONLY_EN
    assign wr_slot_ok = bus.vblank;
`else
    logic unused_vblank;
    assign unused_vblank = bus.vblank;
    assign wr_slot_ok    = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_next;
    end

    // Slot arbitration: clear owns everything, then video, then a pending CPU access.
    always_comb begin
        state_next   = state;
        vid_serve    = 1'b0;
        cpu_issue    = 1'b0;
        cpu_wr_issue = 1'b0;
        cpu_rd_issue = 1'b0;
        req_take     = 1'b0;
        pend_done    = 1'b0;
        mux_addr     = addr_hold;
        mux_we       = 1'b0;
        mux_wdata    = '0;
        if (reset) begin
            state_next = CLEAR;
            mux_addr   = '0;
        end else if (state == CLEAR) begin
            mux_addr = clr_cnt;
            mux_we   = 1'b1;
            if (clr_cnt == LAST_ADDR) state_next = RUN;
        end else begin
            vid_serve    = bus.ce_vid;
            cpu_issue    = !bus.ce_vid && pend_valid && !pend_issued && (!pend.we || wr_slot_ok);
            cpu_wr_issue = cpu_issue && pend.we;
            cpu_rd_issue = cpu_issue && !pend.we;
            req_take     = bus.cpu_req && !pend_valid;
            pend_done    = cpu_wr_issue || tag[1];
            if (vid_serve) begin
                mux_addr = bus.vid_addr;
            end else if (cpu_issue) begin
                mux_addr = pend.addr;
                mux_we   = pend.we;
                if (pend.we) mux_wdata = pend.wdata;
            end
        end
        pend_valid_next = req_take || (pend_valid && !pend_done);
    end

    assign bus.ram_addr  = mux_addr;
    assign bus.ram_we    = mux_we;
    assign bus.ram_wdata = mux_wdata;

    // tag records who owns the ram_q that arrives next cycle: {cpu, video}.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt        <= '0;
            pend           <= '0;
            pend_valid     <= 1'b0;
            pend_issued    <= 1'b0;
            tag            <= 2'b00;
            addr_hold      <= '0;
            bus.vid_data   <= '0;
            bus.cpu_rdata  <= '0;
            bus.cpu_ack    <= 1'b0;
            bus.cpu_ready  <= 1'b0;
            bus.clear_busy <= 1'b1;
        end else begin
            if (state == CLEAR) clr_cnt <= clr_cnt + AW'(1);
            if (req_take) begin
                pend.we    <= bus.cpu_we;
                pend.addr  <= bus.cpu_addr;
                pend.wdata <= bus.cpu_wdata;
            end
            pend_valid     <= pend_valid_next;
            pend_issued    <= pend_valid_next && (pend_issued || cpu_rd_issue);
            tag            <= {cpu_rd_issue, vid_serve};
            addr_hold      <= mux_addr;
            if (tag[0]) bus.vid_data  <= bus.ram_q;
            if (tag[1]) bus.cpu_rdata <= bus.ram_q;
            bus.cpu_ack    <= pend_done;
            bus.cpu_ready  <= (state_next == RUN) && !pend_valid_next;
            bus.clear_busy <= (state_next == CLEAR);
        end
    end
endmodule

// File: doc/blockade_vram_arbiter.md
# blockade_vram_arbiter

Single-port video RAM controller that shares one 1024x8 synchronous RAM between the video fetch path and the 8080 CPU. It replaces the dual-port VRAM arrangement and clears the RAM after reset. It also generates the CPU READY stall used while a VRAM access is waiting for a free slot. It sits between the CPU bus decode (VRAM chip select) and the character/PROM fetch pipeline.

## Interface
- No parameters; RAM geometry is fixed at 1024x8.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce_vid  in  1  video slot strobe, one cycle in every 4
- vid_addr  in  10  video fetch address {vcnt[7:3], hcnt[7:3]}
- vid_data  out  8  fetched character code, registered
- vblank  in  1  vertical blank, active-high
- cpu_req  in  1  single-cycle request strobe
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  10  CPU VRAM address; sampled with cpu_req
- cpu_wdata  in  8  write data; sampled with cpu_req
- cpu_rdata  out  8  read data, registered
- cpu_ack  out  1  one-cycle completion pulse
- cpu_ready  out  1  to 8080 READY; low while clearing or while a request is pending
- clear_busy  out  1  high while the post-reset clear runs
- ram_addr  out  10  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_q  in  8  RAM read data; 1-cycle latency

## Operation
- Top-level FSM states:
  - CLEAR: entered on reset. Writes 0x00 to addresses 0..1023, one per cycle, and owns every cycle, including ce_vid cycles. vid_data is held at 0x00 and cpu_ready stays 0. After address 1023 the FSM goes to RUN.
  - RUN: per-cycle arbitration.
- RUN arbitration:
  - Video has absolute priority. In a ce_vid cycle, ram_addr = vid_addr and ram_we = 0.
  - The CPU is served only in a non-ce_vid cycle, and only when a request is pending and permitted (see Configuration).
- Request capture:
  - cpu_req latches cpu_we, cpu_addr and cpu_wdata into a pending register.
  - cpu_req is ignored while a request is pending or while the FSM is in CLEAR. It is not queued.
- CPU write, issued in cycle T:
  - In T: ram_we = 1, ram_addr = pending address, ram_wdata = pending data.
  - In T+1: cpu_ack = 1 and pending clears.
- CPU read, issued in cycle T:
  - In T: ram_addr = pending address.
  - At the end of T+1: ram_q is captured into cpu_rdata.
  - In T+2: cpu_ack = 1 and pending clears.
- Video read, with ce_vid in cycle V: ram_q is captured into vid_data at the end of V+1, so vid_data is valid from V+2 and is held until the next capture.
- A 2-bit tag pipeline (video/CPU) routes each ram_q to the correct output register. It must handle a CPU read issued in T followed by a video slot in T+1 with no corruption of either result.
- cpu_ready = !(pending || clear_busy || reset). It is registered, so it falls in the cycle after cpu_req.
- When ram_we = 0 in idle cycles, ram_addr holds its last value.

## Timing
- Values while and immediately after reset:
  - vid_data, cpu_rdata: 0x00
  - cpu_ack, ram_we, cpu_ready: 0
  - ram_addr: 0
  - clear_busy: 1
- Clear timing:
  - The first clear write occurs in the first cycle after reset deasserts.
  - clear_busy falls 1024 cycles after that first write.
  - cpu_ready rises in the same cycle clear_busy falls.
- Minimum CPU latency, with cpu_req in cycle S:
  - Issue in S+1.
  - Write ack in S+2.
  - Read ack in S+3, with cpu_rdata valid in the same cycle.
- A ce_vid in the would-be issue cycle delays the CPU access by exactly 1 cycle.
- Reset asserted mid-operation:
  - The pending request is dropped and no ack is issued.
  - Any in-flight capture is discarded.
  - The clear restarts at address 0.

## Configuration
- VRAM_VBLANK_ONLY_EN:
  - Defined: pending CPU writes are issued only in cycles where vblank = 1. cpu_ready stays low through active display, matching original board behaviour. CPU reads still use any free slot.
  - Undefined: CPU writes use any free non-ce_vid slot.

## Test plan
- Reset release: 1024 writes of 0x00 to ascending addresses; clear_busy falls on cycle 1024; vid_data = 0x00 throughout; cpu_req during clear is ignored (no ack).
- Write then read: write 0xA5 to 0x123 in a free slot, then read 0x123. Write ack at S+2; read ack at S+3 with cpu_rdata = 0xA5.
- Collision: cpu_req (read of 0x010, which holds 0x3C) lands so the issue cycle coincides with ce_vid at vid_addr 0x200 (holds 0x11). Video is served first; the CPU is issued 1 cycle later; vid_data = 0x11 and cpu_rdata = 0x3C, with no swap.
- Back-to-back: CPU read issued at T, ce_vid at T+1. Both results land in the correct registers on the stated cycles.
- With VRAM_VBLANK_ONLY_EN, a write requested at vblank = 0: cpu_ready stays 0 and no ram_we until vblank rises; ack on the cycle after vblank's first free slot. Without the macro, ack at S+2.
- Reset asserted one cycle after a read issue: no cpu_ack; cpu_rdata = 0x00; clear restarts at address 0.
